wb_write_ctrl: RTL

//   Writeback controller on the producer side of the 32x32 register file write port (WriteAddr/WriteData/RegWrite).

---
 rtl/regfile_pkg.sv | 20 ++
 rtl/wb_fifo.sv | 55 +++++
 rtl/wb_write_ctrl.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/regfile_pkg.sv
// Shared register-file types: port widths and the writeback queue entry.
package regfile_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int REG_DATA_W = 32;
  localparam int NUM_REGS   = 32;

  typedef struct packed {
    logic                  live;
    logic [REG_ADDR_W-1:0] addr;
    logic [REG_DATA_W-1:0] data;
  } wb_entry_t;

  function automatic logic [NUM_REGS-1:0] reg_onehot(
    input logic [REG_ADDR_W-1:0] a
  );
    return NUM_REGS'(1) << a;
  endfunction

endpackage

// File: rtl/wb_fifo.sv
// Ordered MDU result queue with kill-by-address; all slots visible.
module wb_fifo
  import regfile_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int PW    = $clog2(DEPTH)
) (
  input  logic                   clk,
  input  logic                   Reset,
  input  logic                   i_push,
  input  wb_entry_t              i_push_entry,
  input  logic                   i_pop,
  input  logic                   i_kill,
  input  logic [REG_ADDR_W-1:0]  i_kill_addr,
  output wb_entry_t [DEPTH-1:0]  o_entries,
  output logic [PW-1:0]          o_rd_ptr,
  output logic [PW:0]            o_count
);

  wb_entry_t [DEPTH-1:0] r_mem;
  logic [PW-1:0]         r_rd;
  logic [PW-1:0]         r_wr;
  logic [PW:0]           r_cnt;

  // Free slots always hold live=0, so kill and pending may scan every slot.
  always_ff @(posedge clk) begin
    if (Reset) begin
      r_rd  <= '0;
      r_wr  <= '0;
      r_cnt <= '0;
      for (int i = 0; i < DEPTH; i++)
        r_mem[i].live <= 1'b0;
    end else begin
      for (int i = 0; i < DEPTH; i++)
        if (i_kill && r_mem[i].live &&
            r_mem[i].addr == i_kill_addr)
          r_mem[i].live <= 1'b0;
      if (i_pop) begin
        r_mem[r_rd].live <= 1'b0;
        r_rd             <= r_rd + PW'(1);
      end
      if (i_push) begin
        r_mem[r_wr] <= i_push_entry;
        r_wr        <= r_wr + PW'(1);
      end
      r_cnt <= r_cnt + (PW+1)'(i_push)
                     - (PW+1)'(i_pop);
    end
  end

  assign o_entries = r_mem;
  assign o_rd_ptr  = r_rd;
  assign o_count   = r_cnt;

endmodule

// File: rtl/wb_write_ctrl.sv
// Writeback arbiter merging ALU slot and queued MDU results onto one regfile port.
// Optional forwarding ports are built when WB_FWD_EN is defined.
module wb_write_ctrl
  import regfile_pkg::*;
#(
  parameter  int DEPTH      = 4,
  parameter  int STARVE_MAX = 8,
  localparam int CW         = $clog2(DEPTH),
  localparam int SW         = $clog2(STARVE_MAX + 1)
) (
  input  logic                   clk,
  input  logic                   Reset,
  input  logic                   alu_valid,
  input  logic [REG_ADDR_W-1:0]  alu_addr,
  input  logic [REG_DATA_W-1:0]  alu_data,
  output logic                   wb_stall,
  input  logic                   mdu_valid,
  output logic                   mdu_ready,
  input  logic [REG_ADDR_W-1:0]  mdu_addr,
  input  logic [REG_DATA_W-1:0]  mdu_data,
  output logic [REG_ADDR_W-1:0]  WriteAddr,
  output logic [REG_DATA_W-1:0]  WriteData,
  output logic                   RegWrite,
  output logic [NUM_REGS-1:0]    pending,
  output logic [CW:0]            q_count
`ifdef WB_FWD_EN
  ,
  input  logic [REG_ADDR_W-1:0]  fwd_addr_a,
  input  logic [REG_ADDR_W-1:0]  fwd_addr_b,
  output logic                   fwd_hit_a,
  output logic                   fwd_hit_b,
  output logic [REG_DATA_W-1:0]  fwd_data_a,
  output logic [REG_DATA_W-1:0]  fwd_data_b
`endif
);

  wb_entry_t [DEPTH-1:0] w_entries;
  wb_entry_t             w_head;
  wb_entry_t             w_push_entry;
  logic [CW-1:0]         w_rd_ptr;
  logic [CW:0]           w_count;
  logic                  w_nonempty;
  logic                  w_alu_win;
  logic                  w_pop;
  logic                  w_push;
  logic [NUM_REGS-1:0]   w_pending;
  logic [SW-1:0]         r_starve;

  assign w_nonempty = (w_count != '0);
  assign wb_stall   = (r_starve == SW'(STARVE_MAX)) && w_nonempty;
  assign w_alu_win  = !wb_stall && alu_valid && (alu_addr != '0);
  assign w_pop      = w_nonempty && !w_alu_win;
  assign mdu_ready  = !Reset && (w_count < (CW+1)'(DEPTH));
  assign w_push     = mdu_valid && mdu_ready;
  assign w_head     = w_entries[w_rd_ptr];
  assign q_count    = w_count;

  assign w_push_entry.live = (mdu_addr != '0);
  assign w_push_entry.addr = mdu_addr;
  assign w_push_entry.data = mdu_data;

  wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk          (clk),
    .Reset        (Reset),
    .i_push       (w_push),
    .i_push_entry (w_push_entry),
    .i_pop        (w_pop),
    .i_kill       (w_alu_win),
    .i_kill_addr  (alu_addr),
    .o_entries    (w_entries),
    .o_rd_ptr     (w_rd_ptr),
    .o_count      (w_count)
  );

  always_ff @(posedge clk) begin
    if (Reset) begin
      RegWrite  <= 1'b0;
      WriteAddr <= '0;
      WriteData <= '0;
      r_starve  <= '0;
    end else begin
      RegWrite <= w_alu_win || (w_pop && w_head.live);
      if (w_alu_win) begin
        WriteAddr <= alu_addr;
        WriteData <= alu_data;
      end else if (w_pop && w_head.live) begin
        WriteAddr <= w_head.addr;
        WriteData <= w_head.data;
      end
      if (w_alu_win && w_nonempty)
        r_starve <= (r_starve == SW'(STARVE_MAX)) ?
                    r_starve : r_starve + SW'(1);
      else
        r_starve <= '0;
    end
  end

  always_comb begin
    w_pending = '0;
    for (int i = 0; i < DEPTH; i++)
      if (w_entries[i].live)
        w_pending = w_pending | reg_onehot(w_entries[i].addr);
    w_pending[0] = 1'b0;
  end

  assign pending = w_pending;

`ifdef WB_FWD_EN
  // Scan oldest to youngest so the youngest match wins; write stage overrides.
  function automatic logic [REG_DATA_W:0] fwd_lookup(
    input logic [REG_ADDR_W-1:0] a
  );
    logic                  hit;
    logic [REG_DATA_W-1:0] d;
    logic [CW-1:0]         idx;
    hit = 1'b0;
    d   = '0;
    for (int k = 0; k < DEPTH; k++) begin
      idx = w_rd_ptr + CW'(k);
      if (w_entries[idx].live && w_entries[idx].addr == a) begin
        hit = 1'b1;
        d   = w_entries[idx].data;
      end
    end
    if (RegWrite && WriteAddr == a) begin
      hit = 1'b1;
      d   = WriteData;
    end
    if (a == '0)
      hit = 1'b0;
    return {hit, d};
  endfunction

  always_comb begin
    {fwd_hit_a, fwd_data_a} = fwd_lookup(fwd_addr_a);
    {fwd_hit_b, fwd_data_b} = fwd_lookup(fwd_addr_b);
  end
`endif

endmodule
